timer_irq_ctrl: RTL and testbench

Interrupt controller that sits directly downstream of `timer_top` and consumes its `TMR_OVF` and `TMR_URF` outputs. It edge-detects both events, latches them as sticky W1C pending flags, and counts occurrences with saturating counters. It drives one level interrupt line, masked per source. Software programs and services it through its own APB slave port on the same `PCLK` as the timer.

---
 rtl/timer_irq_pkg.sv | 20 ++
 rtl/timer_irq_ctrl_if.sv | 30 +++
 rtl/irq_event_channel.sv | 60 ++++++
 rtl/timer_irq_ctrl.sv | 98 +++++++++
 tb/tb_timer_irq_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/timer_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_pkg
// Brief    : Shared register map, IRQ bit indices and counter limit.
// Revision : 1.0
// ============================================================================
package timer_irq_pkg;

  localparam logic [7:0] IER_ADDR  = 8'h00;
  localparam logic [7:0] ISR_ADDR  = 8'h01;
  localparam logic [7:0] OCNT_ADDR = 8'h02;
  localparam logic [7:0] UCNT_ADDR = 8'h03;

  localparam int IRQ_OVF_BIT = 0;
  localparam int IRQ_URF_BIT = 1;

  localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/timer_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_ctrl_if
// Brief    : APB bus bundle between software master and timer_irq_ctrl.
// Revision : 1.0
// ============================================================================
interface timer_irq_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/irq_event_channel.sv
`default_nettype none
// ============================================================================
// Module   : irq_event_channel
// Brief    : Rising-edge detect, sticky pending flag and saturating counter.
// Revision : 1.0
// ============================================================================
module irq_event_channel
  import timer_irq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       evt_in,
  input  logic       pend_clr,
  input  logic       cnt_clr,
  output logic       pending,
  output logic [7:0] count
);

  logic r_prev;
  logic r_pending;
  logic [7:0] r_count;
  logic w_evt;

  assign w_evt = evt_in & ~r_prev;

  // prev resets high so a level already asserted at reset release is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= evt_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_evt) begin
      r_pending <= 1'b1;
    end else if (pend_clr) begin
      r_pending <= 1'b0;
    end
  end

  // A clear coinciding with an event leaves the event counted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 8'h00;
    end else if (cnt_clr) begin
      r_count <= w_evt ? 8'h01 : 8'h00;
    end else if (w_evt && (r_count != CNT_MAX)) begin
      r_count <= r_count + 8'h01;
    end
  end

  assign pending = r_pending;
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_ctrl
// Brief    : APB-programmed interrupt controller for timer OVF/URF events.
// Revision : 1.0
// ============================================================================
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  timer_irq_ctrl_if.slave   apb,
  input  logic              TMR_OVF,
  input  logic              TMR_URF,
  output logic              TMR_IRQ
);

  logic       w_access;
  logic       w_addr_ok;
  logic [1:0] w_sel;
  logic       w_wr;
  logic       w_rd;
  logic       w_ier_we;
  logic       w_isr_we;
  logic [1:0] w_pend_clr;
  logic       w_ocnt_clr;
  logic       w_ucnt_clr;
  logic [1:0] w_pend;
  logic [7:0] w_ocnt;
  logic [7:0] w_ucnt;
  logic [7:0] w_rd8;
  logic [1:0] r_ier;
  logic       w_unused;

  assign w_access  = apb.PSEL & apb.PENABLE & ~PRESET;
  assign w_addr_ok = (apb.PADDR <= ADDR_WIDTH'(UCNT_ADDR));
  assign w_sel     = apb.PADDR[1:0];
  assign w_wr      = w_access & apb.PWRITE & w_addr_ok;
  assign w_rd      = w_access & ~apb.PWRITE & w_addr_ok;

  assign w_ier_we   = w_wr & (w_sel == IER_ADDR[1:0]);
  assign w_isr_we   = w_wr & (w_sel == ISR_ADDR[1:0]);
  assign w_ocnt_clr = w_wr & (w_sel == OCNT_ADDR[1:0]);
  assign w_ucnt_clr = w_wr & (w_sel == UCNT_ADDR[1:0]);
  assign w_pend_clr = {2{w_isr_we}} & apb.PWDATA[1:0];

  assign w_unused = &{1'b0, apb.PWDATA[DATA_WIDTH-1:2]};

  irq_event_channel u_ovf (
    .clk      (PCLK),
    .rst      (PRESET),
    .evt_in   (TMR_OVF),
    .pend_clr (w_pend_clr[IRQ_OVF_BIT]),
    .cnt_clr  (w_ocnt_clr),
    .pending  (w_pend[IRQ_OVF_BIT]),
    .count    (w_ocnt)
  );

  irq_event_channel u_urf (
    .clk      (PCLK),
    .rst      (PRESET),
    .evt_in   (TMR_URF),
    .pend_clr (w_pend_clr[IRQ_URF_BIT]),
    .cnt_clr  (w_ucnt_clr),
    .pending  (w_pend[IRQ_URF_BIT]),
    .count    (w_ucnt)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ier <= 2'b00;
    end else if (w_ier_we) begin
      r_ier <= apb.PWDATA[1:0];
    end
  end

  always_comb begin
    w_rd8 = 8'h00;
    case (w_sel)
      2'd0:    w_rd8 = {6'b0, r_ier};
      2'd1:    w_rd8 = {6'b0, w_pend};
      2'd2:    w_rd8 = w_ocnt;
      default: w_rd8 = w_ucnt;
    endcase
  end

  // Bus outputs are forced low while reset is held, aborting any transfer
  assign apb.PREADY  = w_access;
  assign apb.PSLVERR = w_access & ~w_addr_ok;
  assign apb.PRDATA  = w_rd ? DATA_WIDTH'(w_rd8) : '0;

  assign TMR_IRQ = |(w_pend & r_ier);

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_irq_ctrl
// Brief    : Directed self-checking bench for timer_irq_ctrl.
// Revision : 1.0
// ============================================================================
module tb_timer_irq_ctrl;

  logic PCLK = 1'b0;
  logic PRESET;
  logic TMR_OVF;
  logic TMR_URF;
  logic TMR_IRQ;
  int   checks = 0;
  int   errors = 0;

  timer_irq_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  timer_irq_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .apb     (bus),
    .TMR_OVF (TMR_OVF),
    .TMR_URF (TMR_URF),
    .TMR_IRQ (TMR_IRQ)
  );

  always #5 PCLK = ~PCLK;

  // All tasks start and end 1 time unit after a rising edge
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic ovf_evt, output logic [7:0] rdata,
                          output logic rdy, output logic err);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    if (ovf_evt) TMR_OVF = 1'b1;
    #1;
    rdata = bus.PRDATA; rdy = bus.PREADY; err = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; TMR_OVF = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] d; logic r, e;
    apb_xfer(1'b0, addr, 8'h00, 1'b0, d, r, e);
    chk(name, d, exp);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] d; logic r, e;
    apb_xfer(1'b1, addr, data, 1'b0, d, r, e);
  endtask

  task automatic pulse(input logic ovf);
    if (ovf) TMR_OVF = 1'b1; else TMR_URF = 1'b1;
    @(posedge PCLK); #1;
    TMR_OVF = 1'b0; TMR_URF = 1'b0;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic r, e;
    PRESET = 1'b1; TMR_OVF = 1'b1; TMR_URF = 1'b0;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_irq", {7'b0, TMR_IRQ}, 8'h00);
    chk("idle_prdata", bus.PRDATA, 8'h00);
    chk("idle_pready", {7'b0, bus.PREADY}, 8'h00);
    for (int a = 0; a < 4; a++) begin
      apb_xfer(1'b0, 8'(a), 8'h00, 1'b0, d, r, e);
      chk("reset_reg", d, 8'h00);
      chk("reset_pslverr", {7'b0, e}, 8'h00);
      chk("reset_pready", {7'b0, r}, 8'h01);
    end
    TMR_OVF = 1'b0;
    @(posedge PCLK); #1;
    rd_chk("ocnt_high_through_reset", 8'h02, 8'h00);
  endtask

  task automatic test_ovf_irq();
    wr(8'h00, 8'h01);
    TMR_OVF = 1'b1;
    @(posedge PCLK); #1;
    chk("ovf_irq_latency", {7'b0, TMR_IRQ}, 8'h01);
    TMR_OVF = 1'b0;
    @(posedge PCLK); #1;
    rd_chk("ovf_isr", 8'h01, 8'h01);
    rd_chk("ovf_ocnt", 8'h02, 8'h01);
    wr(8'h01, 8'h01);
    chk("w1c_irq_drop", {7'b0, TMR_IRQ}, 8'h00);
    rd_chk("w1c_isr", 8'h01, 8'h00);
  endtask

  task automatic test_urf_masked();
    wr(8'h00, 8'h00);
    repeat (3) pulse(1'b0);
    rd_chk("urf_isr", 8'h01, 8'h02);
    rd_chk("urf_ucnt", 8'h03, 8'h03);
    chk("urf_masked_irq", {7'b0, TMR_IRQ}, 8'h00);
    wr(8'h00, 8'h02);
    chk("urf_enable_irq", {7'b0, TMR_IRQ}, 8'h01);
  endtask

  task automatic test_saturate_and_collide();
    logic [7:0] d; logic r, e;
    repeat (300) pulse(1'b1);
    rd_chk("ocnt_saturate", 8'h02, 8'hFF);
    apb_xfer(1'b1, 8'h02, 8'h00, 1'b1, d, r, e);
    rd_chk("ocnt_clr_with_evt", 8'h02, 8'h01);
    wr(8'h02, 8'h00);
    rd_chk("ocnt_clr", 8'h02, 8'h00);
    apb_xfer(1'b1, 8'h01, 8'h01, 1'b1, d, r, e);
    rd_chk("w1c_with_evt", 8'h01, 8'h03);
    rd_chk("ocnt_after_collide", 8'h02, 8'h01);
  endtask

  task automatic test_bad_addr();
    logic [7:0] d; logic r, e;
    apb_xfer(1'b1, 8'h55, 8'hFF, 1'b0, d, r, e);
    chk("bad_wr_pslverr", {7'b0, e}, 8'h01);
    chk("bad_wr_pready", {7'b0, r}, 8'h01);
    apb_xfer(1'b0, 8'h55, 8'h00, 1'b0, d, r, e);
    chk("bad_rd_pslverr", {7'b0, e}, 8'h01);
    chk("bad_rd_data", d, 8'h00);
    rd_chk("bad_ier_kept", 8'h00, 8'h02);
    apb_xfer(1'b0, 8'h01, 8'h00, 1'b0, d, r, e);
    chk("good_pslverr", {7'b0, e}, 8'h00);
    chk("bad_isr_kept", d, 8'h03);
  endtask

  task automatic test_back_to_back();
    wr(8'h00, 8'h01);
    rd_chk("b2b_ier", 8'h00, 8'h01);
    wr(8'h00, 8'h02);
    rd_chk("b2b_ier2", 8'h00, 8'h02);
  endtask

  task automatic test_reset_mid_xfer();
    chk("pre_reset_irq", {7'b0, TMR_IRQ}, 8'h01);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 8'h00; bus.PWDATA = 8'h03;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1; PRESET = 1'b1;
    #1;
    chk("rst_pready", {7'b0, bus.PREADY}, 8'h00);
    @(posedge PCLK); #1;
    PRESET = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("rst_abort_irq", {7'b0, TMR_IRQ}, 8'h00);
    rd_chk("rst_abort_ier", 8'h00, 8'h00);
    rd_chk("rst_abort_isr", 8'h01, 8'h00);
  endtask

  initial begin
    test_reset();
    test_ovf_irq();
    test_urf_masked();
    test_saturate_and_collide();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
